// File: rtl/wb_decoder_n_if.sv
// Wishbone classic single-master bus as seen by the address decoder: master side,
// per-port slave side (flattened vectors) and captured-fault status.
interface wb_decoder_n_if #(
  parameter int NPORTS = 8,
  parameter int DW     = 32
);
  localparam int SW = DW / 8;

  logic                       m_cyc_i, m_stb_i, m_we_i;
  logic [31:0]                m_adr_i;
  logic [SW-1:0]              m_sel_i;
  logic [DW-1:0]              m_dat_i, m_dat_o;
  logic                       m_ack_o, m_err_o, m_stall_o;

  logic [NPORTS-1:0]          s_cyc_o, s_stb_o;
  logic                       s_we_o;
  logic [31:0]                s_adr_o;
  logic [SW-1:0]              s_sel_o;
  logic [DW-1:0]              s_dat_o;
  logic [NPORTS-1:0][DW-1:0]  s_dat_i;
  logic [NPORTS-1:0]          s_ack_i, s_err_i, s_stall_i;

  logic [31:0]                err_adr_o;
  logic                       err_tmo_o;

  // decoder view
  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_sel_i, m_dat_i,
    input  s_dat_i, s_ack_i, s_err_i, s_stall_i,
    output m_dat_o, m_ack_o, m_err_o, m_stall_o,
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o,
    output err_adr_o, err_tmo_o
  );

  // environment view (CPU master plus slave models)
  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_sel_i, m_dat_i,
    output s_dat_i, s_ack_i, s_err_i, s_stall_i,
    input  m_dat_o, m_ack_o, m_err_o, m_stall_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o,
    input  err_adr_o, err_tmo_o
  );
endinterface

// File: rtl/wb_decoder_n.sv
// Parametrised Wishbone address decoder / response mux with decode-error,
// cross-region and ack-timeout bus errors plus faulting-address capture.

// Per-port gating: forwards cyc/stb to the selected slave and masks its response
// so the top can OR-reduce all ports into the master response.
module wb_decoder_n_port #(
  parameter int DW = 32
) (
  input  logic          hit,
  input  logic          cyc,
  input  logic          stb,
  input  logic [DW-1:0] dat_i,
  input  logic          ack_i,
  input  logic          err_i,
  input  logic          stall_i,
  output logic          s_cyc,
  output logic          s_stb,
  output logic [DW-1:0] dat_o,
  output logic          ack_o,
  output logic          err_o,
  output logic          stall_o
);
  assign s_cyc   = hit & cyc;
  assign s_stb   = hit & stb;
  assign dat_o   = hit ? dat_i : '0;
  assign ack_o   = hit & ack_i;
  assign err_o   = hit & err_i;
  assign stall_o = hit & stall_i;
endmodule

module wb_decoder_n #(
  parameter int                NPORTS  = 8,
  parameter int                BASE    = 28,
  parameter int                SELW    = 4,
  parameter logic [NPORTS-1:0] PORT_EN = '1,
  parameter int                TIMEOUT = 255,
  parameter int                DW      = 32
) (
  input logic           clk_i,
  input logic           rst_ni,
  wb_decoder_n_if.slave bus
);
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ACTIVE, DERR, TERR, WAIT} state_t;

  state_t                    state;
  logic [SELW-1:0]           port, fld, sel;
  logic [TW-1:0]             timer, timer_nxt;
  logic [31:0]               err_adr;
  logic                      err_tmo;
  logic                      mapped, strobe, sel_vld, fwd_stb, resp, tmo_hit;
  logic [NPORTS-1:0]         hit, s_cyc, s_stb, r_ack, r_err, r_stall;
  logic [NPORTS-1:0][DW-1:0] r_dat;
  logic [DW-1:0]             m_dat;

  assign fld    = bus.m_adr_i[BASE+SELW-1:BASE];
  assign strobe = bus.m_cyc_i & bus.m_stb_i;

  always_comb begin
    mapped = 1'b0;
    for (int k = 0; k < NPORTS; k++)
      if (fld == SELW'(k)) mapped = PORT_EN[k];
  end

  // Port selection: zero-latency forward on the opening strobe, latched port afterwards.
  // A strobe into another region while ACTIVE is held back from the slave.
  always_comb begin
    sel_vld = 1'b0;
    sel     = port;
    fwd_stb = 1'b0;
    if (rst_ni) begin
      if (state == IDLE && strobe && mapped) begin
        sel_vld = 1'b1;
        sel     = fld;
        fwd_stb = 1'b1;
      end else if (state == ACTIVE) begin
        sel_vld = 1'b1;
        fwd_stb = strobe && (fld == port);
      end
    end
  end

  assign hit = sel_vld ? (NPORTS'(1) << sel) : '0;

  wb_decoder_n_port #(.DW(DW)) u_port [NPORTS-1:0] (
    .hit     (hit),
    .cyc     (bus.m_cyc_i),
    .stb     (fwd_stb),
    .dat_i   (bus.s_dat_i),
    .ack_i   (bus.s_ack_i),
    .err_i   (bus.s_err_i),
    .stall_i (bus.s_stall_i),
    .s_cyc   (s_cyc),
    .s_stb   (s_stb),
    .dat_o   (r_dat),
    .ack_o   (r_ack),
    .err_o   (r_err),
    .stall_o (r_stall)
  );

  always_comb begin
    m_dat = '0;
    for (int k = 0; k < NPORTS; k++) m_dat |= r_dat[k];
  end

  // A response in the expiring cycle wins over the timeout.
  assign resp      = (|r_ack) | (|r_err);
  assign tmo_hit   = (TIMEOUT != 0) && fwd_stb && !resp && (timer == TW'(TIMEOUT - 1));
  assign timer_nxt = (fwd_stb && !resp && !tmo_hit) ? timer + 1'b1 : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      port    <= '0;
      timer   <= '0;
      err_adr <= '0;
      err_tmo <= 1'b0;
    end else begin
      timer <= timer_nxt;
      case (state)
        IDLE: if (strobe) begin
          if (mapped) begin
            port  <= fld;
            state <= tmo_hit ? TERR : ACTIVE;
          end else begin
            state <= DERR;
          end
          if (!mapped || tmo_hit) begin
            err_adr <= bus.m_adr_i;
            err_tmo <= tmo_hit;
          end
        end
        ACTIVE: begin
          if (!bus.m_cyc_i) begin
            state <= IDLE;
          end else if (bus.m_stb_i && fld != port) begin
            state   <= DERR;
            err_adr <= bus.m_adr_i;
            err_tmo <= 1'b0;
          end else if (tmo_hit) begin
            state   <= TERR;
            err_adr <= bus.m_adr_i;
            err_tmo <= 1'b1;
          end
        end
        DERR, TERR: state <= WAIT;
        WAIT:       if (!bus.m_cyc_i) state <= IDLE;
        default:    state <= IDLE;
      endcase
    end
  end

  assign bus.m_dat_o   = m_dat;
  assign bus.m_ack_o   = |r_ack;
  assign bus.m_err_o   = (|r_err) | (state == DERR) | (state == TERR);
  assign bus.m_stall_o = |r_stall;
  assign bus.s_cyc_o   = s_cyc;
  assign bus.s_stb_o   = s_stb;
  assign bus.s_we_o    = bus.m_we_i;
  assign bus.s_adr_o   = bus.m_adr_i;
  assign bus.s_sel_o   = bus.m_sel_i;
  assign bus.s_dat_o   = bus.m_dat_i;
  assign bus.err_adr_o = err_adr;
  assign bus.err_tmo_o = err_tmo;
endmodule
